// File: rtl/frame_scheduler_pkg.sv
// ============================================================================
// Module   : lightcube_pkg
// Brief    : Shared frame width, mode_sel encodings and source enum for the
//            LED cube frame path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lightcube_pkg;

    localparam int FRAME_W = 512;

    localparam logic [1:0] MODE_AUTO          = 2'b00;
    localparam logic [1:0] MODE_FORCE_DEFAULT = 2'b01;
    localparam logic [1:0] MODE_FORCE_UART    = 2'b10;

    typedef enum logic [0:0] {
        SRC_DEFAULT = 1'b0,
        SRC_UART    = 1'b1
    } src_e;

endpackage

`default_nettype wire

// File: rtl/frame_scheduler_if.sv
// ============================================================================
// Module   : frame_scheduler_if
// Brief    : Bundle of frame sources, scan handshake and scheduler outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_scheduler_if #(
    parameter int FRAME_W = lightcube_pkg::FRAME_W
);
    logic [1:0]         mode_sel;
    logic [FRAME_W-1:0] frame_cube_uart_flat;
    logic               frame_valid_uart;
    logic [FRAME_W-1:0] frame_cube_default_flat;
    logic               frame_valid_default;
    logic               scan_done;
    logic [FRAME_W-1:0] frame_cube_flat;
    logic               active_src;
    logic               frame_swap;
    logic               gen_enable;
    logic [7:0]         drop_cnt;

    modport slave (
        input  mode_sel, frame_cube_uart_flat, frame_valid_uart,
               frame_cube_default_flat, frame_valid_default, scan_done,
        output frame_cube_flat, active_src, frame_swap, gen_enable, drop_cnt
    );

    modport master (
        output mode_sel, frame_cube_uart_flat, frame_valid_uart,
               frame_cube_default_flat, frame_valid_default, scan_done,
        input  frame_cube_flat, active_src, frame_swap, gen_enable, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/frame_scheduler_commit_buf.sv
// ============================================================================
// Module   : frame_commit_buf
// Brief    : Pending-frame double buffer; commits to the display frame at a
//            scan boundary (SCAN_SYNC_EN) or on the cycle after capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_commit_buf #(
    parameter int FRAME_W = lightcube_pkg::FRAME_W
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic               i_cap,
    input  wire logic [FRAME_W-1:0] i_cap_data,
    input  wire logic               i_clear,
    input  wire logic               i_scan_done,
    output logic      [FRAME_W-1:0] o_frame,
    output logic                    o_swap,
    output logic      [7:0]         o_drop_cnt
);
    logic [FRAME_W-1:0] r_pend;
    logic               r_pend_vld;
    logic [FRAME_W-1:0] r_frame;
    logic               r_swap;
    logic [7:0]         r_drop;
    logic               w_gate;
    logic               w_commit;
    logic               w_drop;

`ifdef SCAN_SYNC_EN
    assign w_gate = i_scan_done;
`else
    logic w_unused_scan;
    assign w_unused_scan = i_scan_done;
    assign w_gate        = 1'b1;
`endif

    // A source-switch clear discards the pending frame instead of showing it.
    assign w_commit = w_gate && r_pend_vld && !i_clear;
    assign w_drop   = i_cap && r_pend_vld && !w_commit && !i_clear;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_frame    <= '0;
            r_swap     <= 1'b0;
            r_drop     <= 8'd0;
        end else begin
            r_swap <= w_commit;
            if (w_commit) begin
                r_frame <= r_pend;
            end
            if (i_cap) begin
                r_pend     <= i_cap_data;
                r_pend_vld <= 1'b1;
            end else if (w_commit || i_clear) begin
                r_pend_vld <= 1'b0;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign o_frame    = r_frame;
    assign o_swap     = r_swap;
    assign o_drop_cnt = r_drop;

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// ============================================================================
// Module   : frame_scheduler
// Brief    : Source select FSM (UART takeover / timeout fallback / forced
//            modes) feeding a tear-free commit buffer. Macro: SCAN_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_scheduler
    import lightcube_pkg::*;
#(
    parameter int FRAME_W     = lightcube_pkg::FRAME_W,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int CNT_W       = 27
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    frame_scheduler_if.slave  bus
);
    localparam logic [0:0]       ST_DEFAULT = 1'(SRC_DEFAULT);
    localparam logic [0:0]       ST_UART    = 1'(SRC_UART);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_gen_en;
    logic [0:0]         w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_forced;
    logic               w_clear;
    logic               w_cap_uart;
    logic               w_cap_def;
    logic [FRAME_W-1:0] w_cap_data;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = '0;
        case (bus.mode_sel)
            MODE_FORCE_DEFAULT: w_nxt_state = ST_DEFAULT;
            MODE_FORCE_UART:    w_nxt_state = ST_UART;
            default: begin
                if (r_state == ST_DEFAULT) begin
                    if (bus.frame_valid_uart) begin
                        w_nxt_state = ST_UART;
                    end
                end else if (!bus.frame_valid_uart) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_nxt_state = ST_DEFAULT;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_forced = (bus.mode_sel == MODE_FORCE_DEFAULT) ||
                      (bus.mode_sel == MODE_FORCE_UART);
    assign w_clear  = w_forced && (w_nxt_state != r_state);

    // Capture follows the state being entered, so a takeover strobe is kept.
    assign w_cap_uart = bus.frame_valid_uart    && (w_nxt_state == ST_UART);
    assign w_cap_def  = bus.frame_valid_default && (w_nxt_state == ST_DEFAULT);
    assign w_cap_data = w_cap_uart ? bus.frame_cube_uart_flat
                                   : bus.frame_cube_default_flat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_DEFAULT;
            r_cnt    <= '0;
            r_gen_en <= 1'b1;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_gen_en <= (bus.mode_sel != MODE_FORCE_UART);
        end
    end

    assign bus.active_src = r_state[0];
    assign bus.gen_enable = r_gen_en;

    frame_commit_buf #(
        .FRAME_W (FRAME_W)
    ) u_commit_buf (
        .clk         (clk),
        .resetn      (resetn),
        .i_cap       (w_cap_uart || w_cap_def),
        .i_cap_data  (w_cap_data),
        .i_clear     (w_clear),
        .i_scan_done (bus.scan_done),
        .o_frame     (bus.frame_cube_flat),
        .o_swap      (bus.frame_swap),
        .o_drop_cnt  (bus.drop_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// ============================================================================
// Module   : tb_frame_scheduler
// Brief    : Directed bench; expected frames are queued at stimulus time and
//            popped on every frame_swap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_scheduler;
    import lightcube_pkg::*;

    localparam int FW = 512;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   n_swap;
    logic [FW-1:0] exp_q[$];
    logic [7:0]    exp_drop;

    frame_scheduler_if #(.FRAME_W(FW)) bus ();

    frame_scheduler #(
        .FRAME_W     (FW),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_def(input logic [7:0] b);
        bus.frame_cube_default_flat = pat(b);
        bus.frame_valid_default     = 1'b1;
        tick();
        bus.frame_valid_default     = 1'b0;
    endtask

    task automatic strobe_uart(input logic [7:0] b);
        bus.frame_cube_uart_flat = pat(b);
        bus.frame_valid_uart     = 1'b1;
        tick();
        bus.frame_valid_uart     = 1'b0;
    endtask

    task automatic scan();
        bus.scan_done = 1'b1;
        tick();
        bus.scan_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_frame"},  bus.frame_cube_flat, '0);
        chk({tag, "_active"}, FW'(bus.active_src), FW'(0));
        chk({tag, "_swap"},   FW'(bus.frame_swap), FW'(0));
        chk({tag, "_drop"},   FW'(bus.drop_cnt), FW'(0));
        chk({tag, "_genen"},  FW'(bus.gen_enable), FW'(1));
    endtask

    // Scoreboard: every swap must match the oldest queued frame.
    always @(negedge clk) begin
        if (resetn && bus.frame_swap) begin
            n_swap++;
            chk("swap_expected", FW'(exp_q.size() != 0), FW'(1));
            if (exp_q.size() != 0) begin
                chk("swap_frame", bus.frame_cube_flat, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        n_swap = 0;
        resetn = 1'b0;
        bus.mode_sel                = MODE_AUTO;
        bus.frame_cube_uart_flat    = '0;
        bus.frame_valid_uart        = 1'b0;
        bus.frame_cube_default_flat = '0;
        bus.frame_valid_default     = 1'b0;
        bus.scan_done               = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        tick();

        // 1: default frame, scan_done 10 cycles later
        exp_q.push_back(pat(8'hA5));
        strobe_def(8'hA5);
        repeat (9) tick();
`ifdef SCAN_SYNC_EN
        chk("t1_hold_before_scan", bus.frame_cube_flat, '0);
`else
        chk("t1_early_commit", bus.frame_cube_flat, pat(8'hA5));
`endif
        scan();
        chk("t1_frame", bus.frame_cube_flat, pat(8'hA5));
        chk("t1_active", FW'(bus.active_src), FW'(0));
        tick();
        chk("t1_swap_count", FW'(n_swap), FW'(1));

        // 2: simultaneous UART + default strobes, UART wins
        exp_q.push_back(pat(8'h3C));
        bus.frame_cube_uart_flat    = pat(8'h3C);
        bus.frame_cube_default_flat = pat(8'hC3);
        bus.frame_valid_uart        = 1'b1;
        bus.frame_valid_default     = 1'b1;
        tick();
        bus.frame_valid_uart    = 1'b0;
        bus.frame_valid_default = 1'b0;
        chk("t2_active", FW'(bus.active_src), FW'(1));
        scan();
        chk("t2_frame", bus.frame_cube_flat, pat(8'h3C));

        // 3: timeout fallback exactly 16 cycles after last UART strobe
        exp_q.push_back(pat(8'h11));
        strobe_uart(8'h11);
        scan();
        repeat (14) tick();
        chk("t3_active_before_timeout", FW'(bus.active_src), FW'(1));
        tick();
        chk("t3_active_after_timeout", FW'(bus.active_src), FW'(0));
        chk("t3_frame_held", bus.frame_cube_flat, pat(8'h11));

        // 4: three default strobes, no scan in between
`ifdef SCAN_SYNC_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
        exp_q.push_back(pat(8'h01));
        exp_q.push_back(pat(8'h02));
`endif
        exp_q.push_back(pat(8'h03));
        strobe_def(8'h01);
        strobe_def(8'h02);
        strobe_def(8'h03);
        chk("t4_drop", FW'(bus.drop_cnt), FW'(exp_drop));
        scan();
        chk("t4_frame", bus.frame_cube_flat, pat(8'h03));

        // 5: capture coincides with scan_done while pending is full
        exp_q.push_back(pat(8'h0A));
        exp_q.push_back(pat(8'h0B));
        strobe_def(8'h0A);
        bus.frame_cube_default_flat = pat(8'h0B);
        bus.frame_valid_default     = 1'b1;
        bus.scan_done               = 1'b1;
        tick();
        bus.frame_valid_default = 1'b0;
        bus.scan_done           = 1'b0;
        chk("t5_old_commit", bus.frame_cube_flat, pat(8'h0A));
        scan();
        chk("t5_new_commit", bus.frame_cube_flat, pat(8'h0B));
        chk("t5_drop", FW'(bus.drop_cnt), FW'(exp_drop));

        // 6: FORCE_UART ignores default frames and never times out
        bus.mode_sel = MODE_FORCE_UART;
        tick();
        chk("t6_genen", FW'(bus.gen_enable), FW'(0));
        chk("t6_active", FW'(bus.active_src), FW'(1));
        strobe_def(8'h77);
        scan();
        repeat (20) tick();
        chk("t6_default_ignored", bus.frame_cube_flat, pat(8'h0B));
        chk("t6_no_timeout", FW'(bus.active_src), FW'(1));
        exp_q.push_back(pat(8'h55));
        strobe_uart(8'h55);
        scan();
        chk("t6_uart_frame", bus.frame_cube_flat, pat(8'h55));
        strobe_uart(8'h66);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("t6_async_reset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) tick();
        chk("sb_drained", FW'(exp_q.size()), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences the frame path between the two animation sources (UART receiver, default frame generator) and the layer-scan Display.
- Selects the active source: automatic UART takeover with timeout fallback, or forced by mode.
- Double-buffers the selected frame and commits it only at a scan boundary, giving tear-free updates.
- Sits between uart_reciver/frame_gen and Display.

Parameters:
FRAME_W, 512, flattened cube width (8 layers x 64 LEDs)
TIMEOUT_CYC, 100000000, clk cycles without a UART frame before AUTO falls back to default (1 s at 100 MHz)
CNT_W, 27, timeout counter width, must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  100 MHz system clock
resetn  in  1  reset, asynchronous, active-low
mode_sel  in  2  00 AUTO, 01 FORCE_DEFAULT, 10 FORCE_UART, 11 treated as AUTO
frame_cube_uart_flat  in  FRAME_W  UART frame data
frame_valid_uart  in  1  1-cycle strobe, UART frame valid
frame_cube_default_flat  in  FRAME_W  default-animation frame data
frame_valid_default  in  1  1-cycle strobe, default frame valid
scan_done  in  1  1-cycle pulse from Display after the last layer of a full scan
frame_cube_flat  out  FRAME_W  committed frame to Display
active_src  out  1  0 = default, 1 = UART
frame_swap  out  1  1-cycle pulse when frame_cube_flat is updated
gen_enable  out  1  enable for frame_gen
drop_cnt  out  8  saturating count of pending frames overwritten before commit

Behaviour:
- Reset (async on resetn low):
  - Outputs: frame_cube_flat=0, active_src=0, frame_swap=0, drop_cnt=0, gen_enable=1.
  - Internal: state=SRC_DEFAULT, pending empty, timeout counter 0.
- States: SRC_DEFAULT, SRC_UART. active_src = (state==SRC_UART), registered.
- AUTO mode:
  - SRC_DEFAULT -> SRC_UART on frame_valid_uart. That UART frame is captured in the same cycle.
  - SRC_UART:
    - Counter clears on each frame_valid_uart and otherwise increments.
    - When the counter reaches TIMEOUT_CYC-1 -> SRC_DEFAULT, counter cleared.
- FORCE_DEFAULT / FORCE_UART:
  - State is forced to the matching value on the next clk edge. Timeout is disabled.
  - When a mode change alters the state, pending is cleared.
- Capture:
  - Only the source matching the state (or the state being entered) writes pending.
  - The other source's strobes are ignored.
  - frame_valid_uart and frame_valid_default in the same cycle while in SRC_DEFAULT (AUTO): UART wins.
- Pending full and a new capture arrives: pending is overwritten, drop_cnt increments and saturates at 255.
- Commit:
  - On scan_done with pending full, frame_cube_flat <= pending, pending cleared, frame_swap=1 next cycle.
  - On scan_done with pending empty: no change, frame_swap stays 0.
- Capture and scan_done in the same cycle:
  - The old pending content commits.
  - The new frame becomes pending. No drop is counted.
  - If pending was empty, the new frame is captured and waits for the next scan_done.
- Latency: frame visible on frame_cube_flat 1 cycle after the first scan_done following its capture.
- gen_enable = 0 only in FORCE_UART, registered.
- frame_cube_flat holds its last value across source switches. No blanking.

Optional Feature:
- Macro: SCAN_SYNC_EN.
- Defined: commit is gated by scan_done as above.
- Undefined:
  - scan_done is ignored.
  - A pending frame commits on the cycle after capture, so latency is 2 cycles.
  - drop_cnt only increments on a capture that coincides with an uncommitted pending frame, which is impossible, so it stays 0.

Decomposition:
- Shared package lightcube_pkg:
  - FRAME_W constant.
  - mode_sel encodings MODE_AUTO, MODE_FORCE_DEFAULT, MODE_FORCE_UART.
  - Source enum SRC_DEFAULT/SRC_UART.
- Natural sub-module frame_commit_buf:
  - Contains the pending register, pending flag, commit logic, frame_swap and drop_cnt.
  - Inputs: capture strobe, data, clear, scan_done.
- The top holds the source FSM and timeout counter.

Test Plan:
1. Reset, AUTO. Default strobe with data 0xA5-pattern, scan_done 10 cycles later -> frame_cube_flat=pattern one cycle after scan_done; frame_swap pulses once; active_src=0.
2. AUTO, UART strobe and default strobe in the same cycle -> active_src=1 next cycle; the UART frame commits at the next scan_done; the default frame is never shown.
3. AUTO in SRC_UART with TIMEOUT_CYC=16, no further UART frames -> active_src returns to 0 exactly 16 cycles after the last UART strobe.
4. Three default strobes with no scan_done between them -> drop_cnt=2; the third frame commits on scan_done.
5. Capture in the same cycle as scan_done with pending full -> the old frame commits and the new frame commits at the following scan_done; drop_cnt unchanged.
6. FORCE_UART -> gen_enable=0 and default strobes ignored; resetn pulsed low mid-operation -> all outputs immediately return to reset values.
